// File: rtl/gps_acc_pkg.sv
// gps_acc_pkg: register offsets, accumulator field codes, collector FSM states and address helpers
package gps_acc_pkg;
  localparam logic [7:0] OFF_PI     = 8'h18;
  localparam logic [7:0] OFF_PQ     = 8'h1C;
  localparam logic [7:0] OFF_LI     = 8'h20;
  localparam logic [7:0] OFF_LQ     = 8'h24;
  localparam logic [7:0] OFF_EI     = 8'h28;
  localparam logic [7:0] OFF_EQ     = 8'h2C;
  localparam logic [7:0] OFF_STATUS = 8'h30;
  typedef enum logic [2:0] {FLD_PI, FLD_PQ, FLD_LI, FLD_LQ, FLD_EI, FLD_EQ} field_e;
  typedef enum logic [2:0] {S_IDLE, S_POLL, S_CHECK, S_READ, S_CLEAR, S_NEXT} state_e;
  function automatic logic [7:0] field_off(input logic [2:0] f);
    return OFF_PI + {3'b000, f, 2'b00};
  endfunction
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] stride,
                                           input logic [2:0] ch, input logic [7:0] off);
    return base + 32'(ch) * stride + {24'h0, off};
  endfunction
endpackage

// File: rtl/gps_acc_fifo.sv
// gps_acc_fifo: first-word-fall-through FIFO; ports clk_i/rst_i, push_i/din_i write, pop_i/dout_o read, count_o/full_o/empty_o status
module gps_acc_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  assign rd = pop_i && !empty_o;
  assign wr = push_i && (!full_o || rd);
  assign wp_d = wp_q + AW'(wr);
  assign rp_d = rp_q + AW'(rd);
  assign cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk_i)
    if (wr) mem_q[wp_q] <= din_i;
  assign dout_o = mem_q[rp_q];
  assign count_o = cnt_q;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/gps_acc_collector.sv
// gps_acc_collector: scans tracking channels over a Wishbone master, dumps ready accumulator records into a FIFO; ports wb clk/rst, enable/mask, wbm_* bus, dump_* stream, skip_cnt_o, bus_err_o
module gps_acc_collector import gps_acc_pkg::*; #(
  parameter int          NUM_CH     = 2,
  parameter logic [31:0] CH_BASE    = 32'h00000A00,
  parameter logic [31:0] CH_STRIDE  = 32'h00000100,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TIMEOUT    = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic [31:0]       wbm_dat_i,
  output logic              wbm_we_o,
  output logic              wbm_stb_o,
  output logic              wbm_cyc_o,
  output logic [3:0]        wbm_sel_o,
  input  logic              wbm_ack_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [31:0]       dump_data_o,
  output logic [5:0]        dump_tag_o,
  output logic [15:0]       skip_cnt_o,
  output logic              bus_err_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [2:0] ch_q, ch_d, fld_q, fld_d;
  logic [31:0] stat_q, stat_d;
  logic cyc_q, cyc_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] skip_q, skip_d;
  logic push, ack, tmo_hit, room, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [37:0] fifo_dout;
  logic [7:0] mask_w, off;
  assign mask_w = 8'(ch_mask_i);
  assign ack = cyc_q && wbm_ack_i;
  assign tmo_hit = cyc_q && !wbm_ack_i && tmo_q == TW'(TIMEOUT - 1);
  assign room = !fifo_full && fifo_cnt <= CW'(FIFO_DEPTH - 6);
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    fld_d = fld_q;
    stat_d = stat_q;
    cyc_d = cyc_q;
    err_d = err_q;
    skip_d = skip_q;
    push = 1'b0;
    tmo_d = (cyc_q && !wbm_ack_i) ? tmo_q + TW'(1) : '0;
    // access states raise cyc on entry (or after the idle gap) and drop it on ack or timeout
    if (state_q inside {S_POLL, S_READ, S_CLEAR}) begin
      cyc_d = !(cyc_q && (wbm_ack_i || tmo_hit));
      if (tmo_hit) begin
        err_d = 1'b1;
        state_d = S_NEXT;
      end
    end
    case (state_q)
      S_IDLE: state_d = !enable_i ? S_IDLE : mask_w[ch_q] ? S_POLL : S_NEXT;
      S_POLL:
        if (ack) begin
          stat_d = wbm_dat_i;
          state_d = S_CHECK;
        end
      S_CHECK: begin
        state_d = (enable_i && stat_q[0] && room) ? S_READ : S_NEXT;
        if (enable_i && stat_q[0] && !room && skip_q != 16'hFFFF) skip_d = skip_q + 16'd1;
      end
      S_READ:
        if (ack) begin
          push = 1'b1;
          fld_d = fld_q == FLD_EQ ? 3'd0 : fld_q + 3'd1;
          if (fld_q == FLD_EQ) state_d = S_CLEAR;
        end
      S_CLEAR: if (ack) state_d = S_NEXT;
      S_NEXT: begin
        ch_d = ch_q == 3'(NUM_CH - 1) ? 3'd0 : ch_q + 3'd1;
        fld_d = 3'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ch_q <= '0;
      fld_q <= '0;
      stat_q <= '0;
      cyc_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
      skip_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      fld_q <= fld_d;
      stat_q <= stat_d;
      cyc_q <= cyc_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
      skip_q <= skip_d;
    end
  gps_acc_fifo #(.WIDTH(38), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .push_i (push),
    .din_i  ({ch_q, fld_q, wbm_dat_i}),
    .pop_i  (dump_valid_o && dump_ready_i),
    .dout_o (fifo_dout),
    .count_o(fifo_cnt),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
  assign off = state_q == S_READ ? field_off(fld_q) : OFF_STATUS;
  assign wbm_adr_o = cyc_q ? reg_addr(CH_BASE, CH_STRIDE, ch_q, off) : '0;
  assign wbm_we_o = cyc_q && state_q == S_CLEAR;
  assign wbm_dat_o = wbm_we_o ? {stat_q[31:1], 1'b0} : '0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_sel_o = 4'hF;
  assign dump_valid_o = !fifo_empty;
  assign dump_data_o = dump_valid_o ? fifo_dout[31:0] : '0;
  assign dump_tag_o = dump_valid_o ? fifo_dout[37:32] : '0;
  assign skip_cnt_o = skip_q;
  assign bus_err_o = err_q;
endmodule

// File: doc/gps_acc_collector.md
GPS_ACC_COLLECTOR -- requirements
Module: gps_acc_collector

Interface
REQ-001 Parameter NUM_CH, default 2, number of tracking channels scanned (1..8).
REQ-002 Parameter CH_BASE, default 32'h00000A00, byte address of channel 0 register block.
REQ-003 Parameter CH_STRIDE, default 32'h00000100, address step between channel blocks.
REQ-004 Parameter FIFO_DEPTH, default 16, dump FIFO entries (power of two, >= 8).
REQ-005 Parameter TIMEOUT, default 255, wb_clk_i cycles allowed per bus access before abort.
REQ-006 wb_clk_i  in  1  single clock for all logic.
REQ-007 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-008 enable_i  in  1  scan enable; low finishes current access, then idles.
REQ-009 ch_mask_i  in  NUM_CH  per-channel scan enable.
REQ-010 wbm_adr_o / wbm_dat_o  out  32 / 32  Wishbone master address / write data.
REQ-011 wbm_dat_i  in  32  Wishbone read data.
REQ-012 wbm_we_o, wbm_stb_o, wbm_cyc_o  out  1 each  Wishbone classic controls; wbm_sel_o out 4, always 4'hF.
REQ-013 wbm_ack_i  in  1  Wishbone acknowledge.
REQ-014 dump_valid_o / dump_ready_i  out / in  1 / 1  FIFO read-side handshake.
REQ-015 dump_data_o  out  32  accumulator word.
REQ-016 dump_tag_o  out  6  {channel[2:0], field[2:0]}; field 0..5 = PI,PQ,LI,LQ,EI,EQ.
REQ-017 skip_cnt_o  out  16  dumps deferred for lack of FIFO space, saturating.
REQ-018 bus_err_o  out  1  sticky, set on any access timeout.

Function
REQ-019 Channel c register address SHALL be CH_BASE + c*CH_STRIDE + offset; offsets PI 0x18, PQ 0x1C, LI 0x20, LQ 0x24, EI 0x28, EQ 0x2C, STATUS 0x30.
REQ-020 FSM states SHALL be IDLE, POLL, CHECK, READ, CLEAR, NEXT.
REQ-021 IDLE -> POLL when enable_i=1 and the current channel's ch_mask_i bit is 1; otherwise NEXT.
REQ-022 POLL SHALL read STATUS; CHECK: bit0=0 -> NEXT; bit0=1 and FIFO free >= 6 -> READ; bit0=1 and free < 6 -> skip_cnt_o+1, NEXT (STATUS left set, retried next pass).
REQ-023 READ SHALL read the six accumulators in PI,PQ,LI,LQ,EI,EQ order, pushing each word with its tag on the ack cycle.
REQ-024 CLEAR SHALL write the polled STATUS value with bit0 forced to 0.
REQ-025 NEXT SHALL advance channel index modulo NUM_CH (NUM_CH-1 wraps to 0) and return to IDLE.
REQ-026 Each access: cyc/stb asserted with address the cycle after state entry, held until ack; deasserted the cycle after ack; one idle bus cycle between accesses.
REQ-027 Counter reaching TIMEOUT without ack SHALL drop cyc/stb, set bus_err_o, abandon the channel (no CLEAR), go NEXT; words already pushed remain.
REQ-028 FIFO SHALL be first-word-fall-through; pop when dump_valid_o and dump_ready_i; push and pop in the same cycle legal at any fill level.
REQ-029 enable_i deassertion mid-dump SHALL complete the six reads and CLEAR before IDLE, so records are never partial.
REQ-030 ch_mask_i SHALL be sampled only in IDLE.
REQ-031 bus_err_o SHALL clear only by reset; skip_cnt_o saturates at 16'hFFFF.

Reset
REQ-032 On wb_rst_i all outputs 0 (wbm_sel_o 4'hF), FSM IDLE, channel index 0, FIFO empty, counters 0, immediately and asynchronously.
REQ-033 Reset mid-access SHALL drop cyc/stb at once; no CLEAR is issued.

Structure
REQ-034 Register offsets, field codes and FSM state encoding SHALL live in shared package gps_acc_pkg.
REQ-035 FIFO SHALL be sub-module gps_acc_fifo (params WIDTH, DEPTH; outputs count, full, empty).

Verification
REQ-036 NUM_CH=2, channel-1 STATUS=1, accumulators 0x11..0x66 -> six FIFO words tagged 6'o10..6'o15 in order, then STATUS write of 0x0 to 0xB30.
REQ-037 Both STATUS=0 -> only reads of 0xA30, 0xB30 alternating; FIFO stays empty.
REQ-038 dump_ready_i=0, both channels ready, FIFO_DEPTH=8 -> first dump fills 6, second deferred, skip_cnt_o increments each pass; ready=1 -> second dump completes.
REQ-039 Slave withholds ack on 0xA1C -> after 255 cycles cyc drops, bus_err_o=1, one PI word in FIFO, no write to 0xA30.
REQ-040 enable_i dropped after first accumulator read -> remaining five reads and CLEAR complete, then IDLE.
REQ-041 wb_rst_i asserted during READ -> cyc/stb 0 same cycle, FIFO empty, scan restarts at channel 0.
